// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS-subset controller.
//   - opcode / funct constants of the supported instructions
//   - ALU operation and immediate-extension mode encodings
//   - FSM state enum, PC source and ALU operand-B select encodings
//   - decoded instruction class enum
package mc_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Immediate extension mode
  localparam logic [2:0] EXT_ZERO  = 3'b000;
  localparam logic [2:0] EXT_SIGN  = 3'b001;
  localparam logic [2:0] EXT_UPPER = 3'b010;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_EXT     = 2'b10;
  localparam logic [1:0] SRCB_EXT_SH2 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DCD   = 3'd2,
    ST_EXE   = 3'd3,
    ST_MEM   = 3'd4,
    ST_WB    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_RTYPE,
    CL_ADDI,
    CL_ORI,
    CL_LUI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath bus.
//   Datapath -> controller: opcode, funct (from IR), zero, overflow_flag
//                           (ALU status), mem_ready (memory handshake).
//   Controller -> datapath: PC/IR/memory/GPR enables, mux selects,
//                           ALU op (sel) and extension mode (ext_sel).
//   master modport: controller side; slave modport: datapath side.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow_flag;
  logic       mem_ready;

  logic       pc_wr;
  logic [1:0] pc_src;
  logic       ir_wr;
  logic       mem_rd;
  logic       mem_wr;
  logic       i_or_d;
  logic       GPRWr;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic [2:0] sel;
  logic [2:0] ext_sel;

  modport master (
    input  opcode, funct, zero, overflow_flag, mem_ready,
    output pc_wr, pc_src, ir_wr, mem_rd, mem_wr, i_or_d, GPRWr, reg_dst,
           mem_to_reg, alu_srca, alu_srcb, sel, ext_sel
  );

  modport slave (
    output opcode, funct, zero, overflow_flag, mem_ready,
    input  pc_wr, pc_src, ir_wr, mem_rd, mem_wr, i_or_d, GPRWr, reg_dst,
           mem_to_reg, alu_srca, alu_srcb, sel, ext_sel
  );
endinterface

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: combinational instruction decoder.
//   opcode, funct : IR fields
//   iclass        : instruction class (unknown opcode or R-type funct -> ILLEGAL)
//   alu_sel       : ALU operation used in EXE for this instruction
//   ovf_chk       : 1 for add/sub/addi, whose GPR write is dropped on overflow
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [2:0] alu_sel,
  output logic       ovf_chk
);

  always_comb begin
    iclass  = CL_ILLEGAL;
    alu_sel = ALU_ADD;
    ovf_chk = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        iclass = CL_RTYPE;
        case (funct)
          FN_ADD:  begin alu_sel = ALU_ADD; ovf_chk = 1'b1; end
          FN_ADDU: alu_sel = ALU_ADD;
          FN_SUB:  begin alu_sel = ALU_SUB; ovf_chk = 1'b1; end
          FN_SUBU: alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_SLT:  alu_sel = ALU_SLT;
          default: iclass = CL_ILLEGAL;
        endcase
      end
      OP_ADDI: begin iclass = CL_ADDI; alu_sel = ALU_ADD; ovf_chk = 1'b1; end
      OP_ORI:  begin iclass = CL_ORI;  alu_sel = ALU_OR;  end
      OP_LUI:  begin iclass = CL_LUI;  alu_sel = ALU_OR;  end
      OP_LW:   begin iclass = CL_LW;   alu_sel = ALU_ADD; end
      OP_SW:   begin iclass = CL_SW;   alu_sel = ALU_ADD; end
      OP_BEQ:  begin iclass = CL_BEQ;  alu_sel = ALU_SUB; end
      OP_J:    iclass = CL_J;
      default: iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for a MIPS-subset core.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   en        : run enable, sampled in IDLE and at instruction retire
//   bus       : mc_ctrl_if.master -- IR fields, ALU flags, mem handshake in;
//               all datapath enables and selects out
//   illegal   : one-cycle pulse in DCD for an undecodable instruction
//   state     : current FSM state (debug)
//   instr_cnt : retired-instruction counter, wraps at 2^CNT_W
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  mc_ctrl_if.master        bus,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] instr_cnt_reg;
  logic             ovf_q;
  logic             retire;

  iclass_t    iclass;
  logic [2:0] alu_sel;
  logic       ovf_chk;

  logic       pc_wr, ir_wr, mem_rd, mem_wr, i_or_d;
  logic       gpr_wr, reg_dst, mem_to_reg, alu_srca, illegal_c;
  logic [1:0] pc_src, alu_srcb;
  logic [2:0] sel, ext_sel;

  // The IR holds the current instruction from DCD onward, so decoding the
  // live opcode/funct is stable for the rest of the instruction.
  mc_ctrl_dec u_dec (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .iclass  (iclass),
    .alu_sel (alu_sel),
    .ovf_chk (ovf_chk)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      instr_cnt_reg <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (retire)
        instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
      // Overflow is a property of the EXE result; WB uses the latched copy.
      if (state_reg == ST_EXE)
        ovf_q <= bus.overflow_flag;
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    i_or_d     = 1'b0;
    gpr_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_srca   = 1'b0;
    alu_srcb   = SRCB_B;
    sel        = ALU_ADD;
    ext_sel    = EXT_ZERO;
    illegal_c  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (en)
          state_next = ST_FETCH;
      end

      ST_FETCH: begin
        mem_rd   = 1'b1;
        alu_srcb = SRCB_FOUR;
        sel      = ALU_ADD;
        if (bus.mem_ready) begin
          ir_wr      = 1'b1;
          pc_wr      = 1'b1;
          pc_src     = PC_SRC_ALU;
          state_next = ST_DCD;
        end
      end

      ST_DCD: begin
        // Branch target PC + (sext(imm) << 2) lands in ALUOut for beq.
        alu_srcb = SRCB_EXT_SH2;
        ext_sel  = EXT_SIGN;
        sel      = ALU_ADD;
        case (iclass)
          CL_J: begin
            pc_wr  = 1'b1;
            pc_src = PC_SRC_JUMP;
            retire = 1'b1;
          end
          CL_ILLEGAL: begin
            illegal_c  = 1'b1;
            state_next = en ? ST_FETCH : ST_IDLE;
          end
          default: state_next = ST_EXE;
        endcase
      end

      ST_EXE: begin
        alu_srca = 1'b1;
        sel      = alu_sel;
        case (iclass)
          CL_RTYPE: begin
            alu_srcb   = SRCB_B;
            state_next = ST_WB;
          end
          CL_ADDI: begin
            alu_srcb   = SRCB_EXT;
            ext_sel    = EXT_SIGN;
            state_next = ST_WB;
          end
          CL_ORI: begin
            alu_srcb   = SRCB_EXT;
            ext_sel    = EXT_ZERO;
            state_next = ST_WB;
          end
          CL_LUI: begin
            // The datapath forces operand A to 0 under EXT_UPPER, so the
            // OR simply passes imm<<16 through.
            alu_srca   = 1'b0;
            alu_srcb   = SRCB_EXT;
            ext_sel    = EXT_UPPER;
            state_next = ST_WB;
          end
          CL_LW, CL_SW: begin
            alu_srcb   = SRCB_EXT;
            ext_sel    = EXT_SIGN;
            state_next = ST_MEM;
          end
          CL_BEQ: begin
            alu_srcb = SRCB_B;
            pc_src   = PC_SRC_ALUOUT;
            pc_wr    = bus.zero;
            retire   = 1'b1;
          end
          default: state_next = ST_IDLE;
        endcase
      end

      ST_MEM: begin
        i_or_d = 1'b1;
        mem_rd = (iclass == CL_LW);
        mem_wr = (iclass == CL_SW);
        if (bus.mem_ready) begin
          if (iclass == CL_LW)
            state_next = ST_WB;
          else
            retire = 1'b1;
        end
      end

      ST_WB: begin
        gpr_wr     = !(ovf_chk && ovf_q);
        reg_dst    = (iclass == CL_RTYPE);
        mem_to_reg = (iclass == CL_LW);
        retire     = 1'b1;
      end

      default: state_next = ST_IDLE;
    endcase

    if (retire)
      state_next = en ? ST_FETCH : ST_IDLE;
  end

  assign bus.pc_wr      = pc_wr;
  assign bus.pc_src     = pc_src;
  assign bus.ir_wr      = ir_wr;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.i_or_d     = i_or_d;
  assign bus.GPRWr      = gpr_wr;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_srca   = alu_srca;
  assign bus.alu_srcb   = alu_srcb;
  assign bus.sel        = sel;
  assign bus.ext_sel    = ext_sel;

  assign illegal   = illegal_c;
  assign state     = state_reg;
  assign instr_cnt = instr_cnt_reg;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared GPR/ALU/ext datapath for a MIPS-subset core.
- Takes opcode/funct from the external IR plus ALU status flags.
- Per state, drives every datapath enable and select: PC, IR, memory, GPR write, ALU op, ext mode and mux selects.
- Also runs a retired-instruction counter and raises an illegal-opcode flag.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  run enable; sampled only in IDLE and at instruction boundary
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU result==0
overflow_flag  in  1  ALU signed overflow
mem_ready  in  1  memory handshake done
pc_wr  out  1  PC load
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
ir_wr  out  1  IR load
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
i_or_d  out  1  0 PC address, 1 ALUOut address
GPRWr  out  1  register-file write enable
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
alu_srca  out  1  0 PC, 1 A
alu_srcb  out  2  00 B, 01 const 4, 10 ext, 11 ext<<2
sel  out  3  ALU op
ext_sel  out  3  ext mode
illegal  out  1  one-cycle pulse on undecodable instruction
state  out  3  current state, debug
instr_cnt  out  CNT_W  retired instructions

Behaviour:
Encodings:
- State: IDLE=0, FETCH=1, DCD=2, EXE=3, MEM=4, WB=5.
- ALU sel: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- ext_sel: 000 zero-extend, 001 sign-extend, 010 upper (imm<<16).

Reset (rst=0, async):
- state=IDLE, instr_cnt=0, ovf_q=0.
- Every output 0.

Output model:
- Moore outputs from state plus the live opcode/funct; no extra output latency.
- Outputs not listed for a state are 0.

States and transitions:
- IDLE: all outputs 0. Go to FETCH when en=1.
- FETCH:
  - Outputs: mem_rd=1, i_or_d=0, alu_srca=0, alu_srcb=01, sel=000.
  - Hold while mem_ready=0.
  - When mem_ready=1: ir_wr=1, pc_wr=1, pc_src=00, go to DCD.
- DCD:
  - Outputs: alu_srca=0, alu_srcb=11, ext_sel=001, sel=000 (precomputes branch target).
  - j (000010): pc_wr=1, pc_src=10, retire.
  - Illegal opcode or R-type funct: illegal=1, retire not counted, go FETCH or IDLE per en.
  - Otherwise go EXE.
- EXE (alu_srca=1; ovf_q <= overflow_flag):
  - R-type: alu_srcb=00; sel from funct (add/addu→000, sub/subu→001, and→010, or→011, slt→100). Go WB.
  - addi (001000): alu_srcb=10, ext_sel=001, sel=000. Go WB.
  - ori (001101): alu_srcb=10, ext_sel=000, sel=011. Go WB.
  - lui (001111): alu_srca=0, alu_srcb=10, ext_sel=010, sel=011. lui result must not depend on PC; the datapath gates A to 0 when ext_sel=010. Go WB.
  - lw/sw (100011/101011): alu_srcb=10, ext_sel=001, sel=000. Go MEM.
  - beq (000100): alu_srcb=00, sel=001, pc_src=01, pc_wr=zero. Retire.
- MEM:
  - i_or_d=1; lw: mem_rd=1, sw: mem_wr=1.
  - Hold while mem_ready=0.
  - On mem_ready=1: lw goes WB; sw retires.
- WB:
  - GPRWr=1 except add/sub/addi with ovf_q=1 (write suppressed; instruction still retires).
  - reg_dst=1 for R-type else 0; mem_to_reg=1 only for lw.
  - Retire.

Retire:
- instr_cnt+1, wraps at 2^CNT_W.
- Next state = FETCH if en=1, else IDLE.

Cycle counts with mem_ready always high: j 2, beq 3, R/imm 4, sw 4, lw 5.

Boundary and corner cases:
- en=0 mid-instruction: ignored; the instruction completes.
- mem_ready high in the same cycle the state is entered: accepted immediately.
- Overflow on addu/subu: ignored.
- rst asserted mid-instruction: immediate IDLE, counter cleared, no partial writes.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode/funct constants;
  - ALU sel and ext_sel encodings;
  - state enum and pc_src/alu_srcb encodings.
- Sub-module mc_ctrl_dec: combinational opcode/funct → instruction class (RTYPE, ADDI, ORI, LUI, LW, SW, BEQ, J, ILLEGAL), ALU sel, and an ovf_chk bit.

Test Plan:
- Reset then en=1, R-type add (funct 100000), mem_ready=1 → states IDLE,FETCH,DCD,EXE,WB,FETCH; GPRWr=1 with reg_dst=1 in WB; instr_cnt=1.
- addi with overflow_flag=1 in EXE → GPRWr=0 in WB; instr_cnt still increments.
- lw with mem_ready held 0 for 3 cycles in MEM → stays MEM with mem_rd=1, i_or_d=1 for 4 cycles; then WB with mem_to_reg=1.
- beq with zero=1 → pc_wr=1, pc_src=01 in EXE. Repeat with zero=0 → pc_wr stays 0; both 3 cycles.
- Opcode 111111 → illegal pulses 1 cycle in DCD; instr_cnt unchanged; next state FETCH.
- rst pulled low during MEM of sw → mem_wr drops to 0 asynchronously; state=0, instr_cnt=0.
